// File: rtl/peak_stream_out_pkg.sv
// Shared constants, state encoding and helpers for the peak output streamer.
// Supplies defaults for `Np and `PIXEL_NUM_PER_RAM when no project header set them.
`ifndef Np
`define Np 10
`endif
`ifndef PIXEL_NUM_PER_RAM
`define PIXEL_NUM_PER_RAM 3
`endif

package peak_stream_out_pkg;

   localparam int NP_DEF  = `Np;
   localparam int PIX_DEF = `PIXEL_NUM_PER_RAM;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   function automatic int idxW(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/peak_stream_out_if.sv
// Valid/ready beat stream carrying one pixel peak per transfer.
// Master drives the beat, slave answers with outReady.
interface peak_stream_out_if #(
   parameter int NP = 10,
   parameter int IW = 2
);

   logic          outValid;
   logic          outReady;
   logic [NP-1:0] outPeak;
   logic [IW-1:0] outPixelIdx;
   logic          outLast;

   modport master (
      output outValid,
      output outPeak,
      output outPixelIdx,
      output outLast,
      input  outReady
   );

   modport slave (
      input  outValid,
      input  outPeak,
      input  outPixelIdx,
      input  outLast,
      output outReady
   );

endinterface

// File: rtl/peak_frame_bank.sv
// One frame of PIX peak bins: whole-frame load, indexed combinational read.
// Pixel k of the flattened frame lands in entry k.
module peak_frame_bank
   import peak_stream_out_pkg::*;
#(
   parameter int NP  = NP_DEF,
   parameter int PIX = PIX_DEF,
   parameter int IW  = idxW(PIX)
) (
   input  logic              clk,
   input  logic              res,
   input  logic              load,
   input  logic [NP*PIX-1:0] frame,
   input  logic [IW-1:0]     rdIdx,
   output logic [NP-1:0]     rdData
);

   logic [PIX-1:0][NP-1:0] mem;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         mem <= '0;
      end else if (load) begin
         mem <= frame;
      end
   end

   always_comb begin
      rdData = '0;
      if (int'(rdIdx) < PIX) begin
         rdData = mem[rdIdx];
      end
   end

endmodule

// File: rtl/peak_stream_out.sv
// Streams completed peak frames one pixel per beat with a one-deep frame queue.
// Define PEAK_DIST_OFFSET_EN to add distOffset and saturating bin subtraction.
module peak_stream_out
   import peak_stream_out_pkg::*;
#(
   parameter int NP  = NP_DEF,
   parameter int PIX = PIX_DEF
) (
   input  logic              clk,
   input  logic              res,
   input  logic              peakValid,
   input  logic [NP*PIX-1:0] peakResult,
`ifdef PEAK_DIST_OFFSET_EN
   input  logic [NP-1:0]     distOffset,
`endif
   peak_stream_out_if.master strm,
   output logic              overflowErr
);

   localparam int            IW      = idxW(PIX);
   localparam logic [IW-1:0] LASTIDX = IW'(PIX - 1);

   state_t        state;
   logic          act;
   logic          pendV;
   logic [IW-1:0] idx;

   logic          xfer;
   logic          lastXfer;
   logic          ldEn;
   logic          ldSel;
   logic [1:0]    ld;
   logic [NP-1:0] rd [2];
   logic [NP-1:0] raw;

   assign xfer     = (state == STREAM) && strm.outReady;
   assign lastXfer = xfer && (idx == LASTIDX);

   // New frame goes to the idle bank, except when the pending bank is
   // promoted on this edge: then the outgoing active bank takes it.
   assign ldEn  = peakValid && ((state == IDLE) || lastXfer || !pendV);
   assign ldSel = (lastXfer && pendV) ? act : ~act;
   assign ld    = {ldEn && ldSel, ldEn && !ldSel};

   for (genvar g = 0; g < 2; g++) begin : gBank
      peak_frame_bank #(
         .NP  (NP),
         .PIX (PIX),
         .IW  (IW)
      ) uBank (
         .clk    (clk),
         .res    (res),
         .load   (ld[g]),
         .frame  (peakResult),
         .rdIdx  (idx),
         .rdData (rd[g])
      );
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state       <= IDLE;
         act         <= 1'b0;
         pendV       <= 1'b0;
         idx         <= '0;
         overflowErr <= 1'b0;
      end else begin
         if (peakValid && (state == STREAM) && pendV && !lastXfer) begin
            overflowErr <= 1'b1;
         end
         unique case (1'b1)
            (state == IDLE): begin
               if (peakValid) begin
                  state <= STREAM;
                  act   <= ~act;
                  idx   <= '0;
               end
            end
            lastXfer: begin
               idx   <= '0;
               pendV <= pendV && peakValid;
               if (pendV || peakValid) begin
                  act <= ~act;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               if (xfer) begin
                  idx <= idx + IW'(1);
               end
               if (peakValid && !pendV) begin
                  pendV <= 1'b1;
               end
            end
         endcase
      end
   end

   assign raw              = act ? rd[1] : rd[0];
   assign strm.outValid    = (state == STREAM);
   assign strm.outPixelIdx = idx;
   assign strm.outLast     = (state == STREAM) && (idx == LASTIDX);

`ifdef PEAK_DIST_OFFSET_EN
   assign strm.outPeak = (raw > distOffset) ? (raw - distOffset) : '0;
`else
   assign strm.outPeak = raw;
`endif

endmodule

// File: tb/tb_peak_stream_out.sv
// Directed bench for peak_stream_out with PIX=3, NP=10.
// Offset vectors run only when PEAK_DIST_OFFSET_EN is defined.
module tb_peak_stream_out;

   import peak_stream_out_pkg::*;

   localparam int NP  = 10;
   localparam int PIX = 3;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              res = 1'b0;
   logic              peakValid = 1'b0;
   logic [NP*PIX-1:0] peakResult = '0;
   logic              overflowErr;
`ifdef PEAK_DIST_OFFSET_EN
   logic [NP-1:0]     distOffset = '0;
`endif

   int nVec = 0;
   int nBad = 0;

   peak_stream_out_if #(.NP(NP), .IW(IW)) strm ();

   peak_stream_out #(
      .NP  (NP),
      .PIX (PIX)
   ) dut (
      .clk         (clk),
      .res         (res),
      .peakValid   (peakValid),
      .peakResult  (peakResult),
`ifdef PEAK_DIST_OFFSET_EN
      .distOffset  (distOffset),
`endif
      .strm        (strm),
      .overflowErr (overflowErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      nVec++;
      if (obs != exp) begin
         nBad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NP*PIX-1:0] mk(input int a, input int b, input int c);
      logic [NP-1:0] pa, pb, pc;
      pa = NP'(a);
      pb = NP'(b);
      pc = NP'(c);
      return {pc, pb, pa};
   endfunction

   task automatic pulse(input int a, input int b, input int c);
      peakResult = mk(a, b, c);
      peakValid  = 1'b1;
      step();
      peakValid  = 1'b0;
   endtask

   task automatic beat(input string tag, input int pk, input int ix);
      chk({tag, ".vld"}, int'(strm.outValid), 1);
      chk({tag, ".pk"}, int'(strm.outPeak), pk);
      chk({tag, ".ix"}, int'(strm.outPixelIdx), ix);
      chk({tag, ".lst"}, int'(strm.outLast), (ix == PIX - 1) ? 1 : 0);
   endtask

   task automatic idle(input string tag);
      chk({tag, ".vld"}, int'(strm.outValid), 0);
      chk({tag, ".lst"}, int'(strm.outLast), 0);
   endtask

   initial begin
      strm.outReady = 1'b0;
      step();
      step();
      idle("rst");
      chk("rst.pk", int'(strm.outPeak), 0);
      chk("rst.ix", int'(strm.outPixelIdx), 0);
      chk("rst.ovf", int'(overflowErr), 0);
      res = 1'b1;
      step();

      // basic frame, ready held high
      strm.outReady = 1'b1;
      pulse(108, 511, 1022);
      beat("b0", 108, 0);
      step(); beat("b1", 511, 1);
      step(); beat("b2", 1022, 2);
      step(); idle("b3");

      // backpressure 1,0,0,1
      pulse(5, 6, 7);
      beat("r0", 5, 0);
      strm.outReady = 1'b1; step(); beat("r1", 6, 1);
      strm.outReady = 1'b0; step(); beat("r2", 6, 1);
      strm.outReady = 1'b0; step(); beat("r3", 6, 1);
      strm.outReady = 1'b1; step(); beat("r4", 7, 2);
      step(); idle("r5");

      // three frames back-to-back
      pulse(1, 2, 3);
      beat("q1", 1, 0);
      pulse(4, 5, 6);
      beat("q2", 2, 1);
      step(); beat("q3", 3, 2);
      pulse(7, 8, 9);
      beat("q4", 4, 0);
      for (int k = 5; k <= 9; k++) begin
         step();
         beat($sformatf("q%0d", k), k, (k - 1) % 3);
      end
      step(); idle("q10");
      chk("q.ovf", int'(overflowErr), 0);

      // new frame on last beat with empty queue
      pulse(10, 20, 30);
      step(); beat("d1", 20, 1);
      step(); beat("d2", 30, 2);
      pulse(40, 50, 60);
      beat("d3", 40, 0);
      step(); beat("d4", 50, 1);
      step(); beat("d5", 60, 2);
      step(); idle("d6");

      // overflow: queue full, third frame dropped
      strm.outReady = 1'b0;
      pulse(11, 12, 13);
      beat("o1", 11, 0);
      pulse(21, 22, 23);
      beat("o2", 11, 0);
      chk("o2.ovf", int'(overflowErr), 0);
      pulse(31, 32, 33);
      beat("o3", 11, 0);
      chk("o3.ovf", int'(overflowErr), 1);
      strm.outReady = 1'b1;
      step(); beat("o4", 12, 1);
      step(); beat("o5", 13, 2);
      step(); beat("o6", 21, 0);
      step(); beat("o7", 22, 1);
      step(); beat("o8", 23, 2);
      step(); idle("o9");
      chk("o9.ovf", int'(overflowErr), 1);
      res = 1'b0;
      #1;
      chk("o10.ovf", int'(overflowErr), 0);
      step();
      res = 1'b1;
      step();

      // async reset mid-frame
      pulse(100, 200, 300);
      beat("x0", 100, 0);
      step(); beat("x1", 200, 1);
      res = 1'b0;
      #1;
      idle("x2");
      chk("x2.pk", int'(strm.outPeak), 0);
      chk("x2.ix", int'(strm.outPixelIdx), 0);
      step();
      res = 1'b1;
      step();
      idle("x3");
      pulse(7, 8, 9);
      beat("x4", 7, 0);
      step(); beat("x5", 8, 1);
      step(); beat("x6", 9, 2);
      step(); idle("x7");

`ifdef PEAK_DIST_OFFSET_EN
      distOffset = NP'(200);
      pulse(90, 1000, 250);
      beat("f0", 0, 0);
      step(); beat("f1", 800, 1);
      step(); beat("f2", 50, 2);
      step(); idle("f3");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
